// File: rtl/cache_pkg.sv
// Shared cache geometry, FSM state encodings and sizing helpers for the cache controller slice.
package cache_pkg;

  localparam int unsigned DEF_INDEX_W = 6;
  localparam int unsigned DEF_OFF_W   = 2;
  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned WORD_W      = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  typedef logic [WORD_W-1:0] word_t;

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned index_w,
                                        input int unsigned off_w);
    return addr_w - index_w - off_w - 2;
  endfunction

  function automatic int unsigned lines(input int unsigned index_w);
    return 32'd1 << index_w;
  endfunction

  function automatic int unsigned words(input int unsigned off_w);
    return 32'd1 << off_w;
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Word-serial main-memory bus with req/ack handshake; master = cache controller, slave = memory.
interface cache_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  import cache_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  word_t             mem_wdata;
  word_t             mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);

endinterface

// File: rtl/cache_line_array.sv
// Line storage: valid/dirty flops with async clear, unreset tag and data arrays,
// one combinational line read port and one word write port.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = DEF_INDEX_W,
  parameter int unsigned OFF_W   = DEF_OFF_W,
  parameter int unsigned TAG_W   = 22
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INDEX_W-1:0]           i_rd_idx,
  output word_t [(1<<OFF_W)-1:0]       o_rd_line_c,
  output logic [TAG_W-1:0]             o_rd_tag_c,
  output logic                         o_rd_valid_c,
  output logic                         o_rd_dirty_c,
  input  logic                         i_wr_en,
  input  logic [INDEX_W-1:0]           i_wr_idx,
  input  logic [OFF_W-1:0]             i_wr_off,
  input  word_t                        i_wr_data,
  input  logic [INDEX_W-1:0]           i_ctl_idx,
  input  logic                         i_set_dirty,
  input  logic                         i_clr_dirty,
  input  logic                         i_inval,
  input  logic                         i_fill_done,
  input  logic [TAG_W-1:0]             i_fill_tag
);

  localparam int unsigned LINES = lines(INDEX_W);
  localparam int unsigned WORDS = words(OFF_W);

  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic [TAG_W-1:0]   r_tag  [LINES];
  word_t [WORDS-1:0]  r_data [LINES];

  // Status bits: fill completion wins over invalidate, clear-dirty over set-dirty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_inval)     r_valid[i_ctl_idx] <= 1'b0;
      if (i_set_dirty) r_dirty[i_ctl_idx] <= 1'b1;
      if (i_clr_dirty) r_dirty[i_ctl_idx] <= 1'b0;
      if (i_fill_done) begin
        r_valid[i_ctl_idx] <= 1'b1;
        r_dirty[i_ctl_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en)     r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    if (i_fill_done) r_tag[i_ctl_idx]           <= i_fill_tag;
  end

  assign o_rd_line_c  = r_data[i_rd_idx];
  assign o_rd_tag_c   = r_tag[i_rd_idx];
  assign o_rd_valid_c = r_valid[i_rd_idx];
  assign o_rd_dirty_c = r_dirty[i_rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller answering the multi-cycle CPU FSM.
// Optional hit/miss/writeback counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = DEF_INDEX_W,
  parameter int unsigned OFF_W   = DEF_OFF_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  word_t             i_cpu_wdata,
  input  logic              i_cpu_we,
  input  logic              i_writeback,
  input  logic              i_update,
  output word_t             o_cpu_rdata_c,
  output logic              o_miss_c,
  output logic              o_dirty_c,
  cache_ctrl_if.master      mem
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]       o_stat_hits,
  output logic [31:0]       o_stat_misses,
  output logic [31:0]       o_stat_wbs
`endif
);

  localparam int unsigned TAG_W = tag_w(ADDR_W, INDEX_W, OFF_W);
  localparam int unsigned WORDS = words(OFF_W);

  logic [TAG_W-1:0]   w_cpu_tag;
  logic [INDEX_W-1:0] w_cpu_idx;
  logic [OFF_W-1:0]   w_cpu_off;
  logic               w_unused_ok;

  assign w_cpu_tag   = i_cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_cpu_idx   = i_cpu_addr[2+OFF_W +: INDEX_W];
  assign w_cpu_off   = i_cpu_addr[2 +: OFF_W];
  assign w_unused_ok = &{1'b0, i_cpu_addr[1:0]};

  logic [1:0]         r_state, w_state_nxt;
  logic [OFF_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_pend, w_pend_nxt;
  logic [INDEX_W-1:0] r_idx, w_idx_nxt;
  logic [TAG_W-1:0]   r_vtag, w_vtag_nxt;
  logic [TAG_W-1:0]   r_ftag, w_ftag_nxt;
  logic               r_mem_req, w_req_nxt;
  logic               r_mem_we, w_we_nxt;
  logic [ADDR_W-1:0]  r_mem_addr, w_addr_nxt;
  word_t              r_mem_wdata, w_wdata_nxt;

  logic               w_idle, w_hit, w_last;
  logic [OFF_W-1:0]   w_cnt_inc;
  logic [INDEX_W-1:0] w_rd_idx;
  word_t [WORDS-1:0]  w_line;
  logic [TAG_W-1:0]   w_rd_tag;
  logic               w_rd_valid, w_rd_dirty;

  logic               w_wr_en, w_set_dirty, w_clr_dirty, w_inval, w_fill_done;
  logic [INDEX_W-1:0] w_wr_idx;
  logic [OFF_W-1:0]   w_wr_off;
  word_t              w_wr_data;

  // While busy the array is steered to the latched line so victim words stay readable
  assign w_idle    = (r_state == ST_IDLE);
  assign w_rd_idx  = w_idle ? w_cpu_idx : r_idx;
  assign w_hit     = w_idle && w_rd_valid && (w_rd_tag == w_cpu_tag);
  assign w_last    = (r_cnt == OFF_W'(WORDS - 1));
  assign w_cnt_inc = OFF_W'(r_cnt + 1'b1);

  assign o_miss_c      = !w_hit;
  assign o_dirty_c     = w_idle && w_rd_valid && w_rd_dirty;
  assign o_cpu_rdata_c = w_line[w_cpu_off];

  cache_line_array #(
    .INDEX_W (INDEX_W),
    .OFF_W   (OFF_W),
    .TAG_W   (TAG_W)
  ) u_lines (
    .clk          (clk),
    .rst          (rst),
    .i_rd_idx     (w_rd_idx),
    .o_rd_line_c  (w_line),
    .o_rd_tag_c   (w_rd_tag),
    .o_rd_valid_c (w_rd_valid),
    .o_rd_dirty_c (w_rd_dirty),
    .i_wr_en      (w_wr_en),
    .i_wr_idx     (w_wr_idx),
    .i_wr_off     (w_wr_off),
    .i_wr_data    (w_wr_data),
    .i_ctl_idx    (w_rd_idx),
    .i_set_dirty  (w_set_dirty),
    .i_clr_dirty  (w_clr_dirty),
    .i_inval      (w_inval),
    .i_fill_done  (w_fill_done),
    .i_fill_tag   (r_ftag)
  );

  // Next state, next registered bus outputs and array controls
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_idx_nxt   = r_idx;
    w_vtag_nxt  = r_vtag;
    w_ftag_nxt  = r_ftag;
    w_req_nxt   = r_mem_req;
    w_we_nxt    = r_mem_we;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_wr_en     = 1'b0;
    w_wr_idx    = w_cpu_idx;
    w_wr_off    = w_cpu_off;
    w_wr_data   = i_cpu_wdata;
    w_set_dirty = 1'b0;
    w_clr_dirty = 1'b0;
    w_inval     = 1'b0;
    w_fill_done = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_cpu_we && w_hit) begin
          w_wr_en     = 1'b1;
          w_set_dirty = 1'b1;
        end
        if (i_writeback && w_rd_valid && w_rd_dirty) begin
          w_state_nxt = ST_WB;
          w_idx_nxt   = w_cpu_idx;
          w_vtag_nxt  = w_rd_tag;
          w_ftag_nxt  = w_cpu_tag;
          w_cnt_nxt   = '0;
          w_pend_nxt  = i_update;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = {w_rd_tag, w_cpu_idx, {OFF_W{1'b0}}, 2'b00};
          w_wdata_nxt = w_line[0];
        end else if (i_update) begin
          w_state_nxt = ST_FILL;
          w_idx_nxt   = w_cpu_idx;
          w_ftag_nxt  = w_cpu_tag;
          w_cnt_nxt   = '0;
          w_pend_nxt  = 1'b0;
          w_inval     = 1'b1;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = {w_cpu_tag, w_cpu_idx, {OFF_W{1'b0}}, 2'b00};
        end
      end

      ST_WB: begin
        if (i_update) w_pend_nxt = 1'b1;
        if (mem.mem_ack) begin
          if (w_last) begin
            w_clr_dirty = 1'b1;
            w_cnt_nxt   = '0;
            w_pend_nxt  = 1'b0;
            if (r_pend || i_update) begin
              w_state_nxt = ST_FILL;
              w_inval     = 1'b1;
              w_we_nxt    = 1'b0;
              w_addr_nxt  = {r_ftag, r_idx, {OFF_W{1'b0}}, 2'b00};
            end else begin
              w_state_nxt = ST_IDLE;
              w_req_nxt   = 1'b0;
              w_we_nxt    = 1'b0;
            end
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_addr_nxt  = {r_vtag, r_idx, w_cnt_inc, 2'b00};
            w_wdata_nxt = w_line[w_cnt_inc];
          end
        end
      end

      ST_FILL: begin
        if (mem.mem_ack) begin
          w_wr_en   = 1'b1;
          w_wr_idx  = r_idx;
          w_wr_off  = r_cnt;
          w_wr_data = mem.mem_rdata;
          if (w_last) begin
            w_fill_done = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
          end else begin
            w_cnt_nxt  = w_cnt_inc;
            w_addr_nxt = {r_ftag, r_idx, w_cnt_inc, 2'b00};
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_idx       <= '0;
      r_vtag      <= '0;
      r_ftag      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend      <= w_pend_nxt;
      r_idx       <= w_idx_nxt;
      r_vtag      <= w_vtag_nxt;
      r_ftag      <= w_ftag_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] r_stat_hits, r_stat_misses, r_stat_wbs;

  // Every hit cycle is the CPU FSM looking up or storing at a resident line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_wbs    <= '0;
    end else begin
      if (w_hit) r_stat_hits <= r_stat_hits + 32'd1;
      if (w_idle && i_update) r_stat_misses <= r_stat_misses + 32'd1;
      if (w_idle && (w_state_nxt == ST_WB)) r_stat_wbs <= r_stat_wbs + 32'd1;
    end
  end

  assign o_stat_hits   = r_stat_hits;
  assign o_stat_misses = r_stat_misses;
  assign o_stat_wbs    = r_stat_wbs;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl: fill, store, writeback+refill, retry loop, reset abort.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  word_t       cpu_wdata;
  logic        cpu_we;
  logic        writeback;
  logic        update;
  word_t       cpu_rdata;
  logic        miss;
  logic        dirty;

  int n_vec;
  int n_err;

  cache_ctrl_if #(.ADDR_W(32)) mem_bus ();

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_wbs;
`endif

  cache_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_cpu_addr    (cpu_addr),
    .i_cpu_wdata   (cpu_wdata),
    .i_cpu_we      (cpu_we),
    .i_writeback   (writeback),
    .i_update      (update),
    .o_cpu_rdata_c (cpu_rdata),
    .o_miss_c      (miss),
    .o_dirty_c     (dirty),
    .mem           (mem_bus)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .o_stat_hits   (stat_hits),
    .o_stat_misses (stat_misses),
    .o_stat_wbs    (stat_wbs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory side of a read burst: check each request, then ack it with d0+i
  task automatic fill_words(input logic [31:0] base, input logic [31:0] d0);
    for (int i = 0; i < 4; i++) begin
      check("fill_req",  32'(mem_bus.mem_req), 32'd1);
      check("fill_we",   32'(mem_bus.mem_we), 32'd0);
      check("fill_addr", mem_bus.mem_addr, base + 32'(i * 4));
      mem_bus.mem_rdata = d0 + 32'(i);
      mem_bus.mem_ack   = 1'b1;
      tick();
      mem_bus.mem_ack   = 1'b0;
    end
  endtask

  // Memory side of a write burst with the expected victim words
  task automatic wb_words(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] exp_w [4];
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      check("wb_req",   32'(mem_bus.mem_req), 32'd1);
      check("wb_we",    32'(mem_bus.mem_we), 32'd1);
      check("wb_addr",  mem_bus.mem_addr, base + 32'(i * 4));
      check("wb_wdata", mem_bus.mem_wdata, exp_w[i]);
      mem_bus.mem_ack = 1'b1;
      tick();
      mem_bus.mem_ack = 1'b0;
    end
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    cpu_addr = 32'h40;
    cpu_wdata = '0;
    cpu_we = 1'b0;
    writeback = 1'b0;
    update = 1'b0;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state and cold miss
    check("rst_req",   32'(mem_bus.mem_req), 32'd0);
    check("rst_we",    32'(mem_bus.mem_we), 32'd0);
    check("rst_addr",  mem_bus.mem_addr, 32'd0);
    check("rst_wdata", mem_bus.mem_wdata, 32'd0);
    check("cold_miss", 32'(miss), 32'd1);
    check("cold_dirty", 32'(dirty), 32'd0);

    // Clean miss fill of line 4
    tick();
    pulse_update();
    check("busy_miss", 32'(miss), 32'd1);
    fill_words(32'h40, 32'hA0);
    check("fill_hit",   32'(miss), 32'd0);
    check("fill_rdata", cpu_rdata, 32'hA0);
    check("fill_idle",  32'(mem_bus.mem_req), 32'd0);
    check("fill_clean", 32'(dirty), 32'd0);

    // Store hit marks the line dirty
    cpu_addr = 32'h44;
    cpu_wdata = 32'hDEAD_BEEF;
    cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    check("st_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("st_dirty", 32'(dirty), 32'd1);
    cpu_addr = 32'h1044;
    #1;
    check("conf_miss",  32'(miss), 32'd1);
    check("conf_dirty", 32'(dirty), 32'd1);

    // Writeback pulse, then update next cycle while WB is stalled
    writeback = 1'b1;
    tick();
    writeback = 1'b0;
    check("wb_dirty_busy", 32'(dirty), 32'd0);
    check("wb_miss_busy",  32'(miss), 32'd1);
    pulse_update();
    wb_words(32'h40, 32'hA0, 32'hDEAD_BEEF, 32'hA2, 32'hA3);
    fill_words(32'h1040, 32'hB0);
    check("refill_hit",   32'(miss), 32'd0);
    check("refill_dirty", 32'(dirty), 32'd0);
    check("refill_rdata", cpu_rdata, 32'hB1);

    // Writeback on a clean line is ignored
    writeback = 1'b1;
    tick();
    writeback = 1'b0;
    check("clean_wb_req", 32'(mem_bus.mem_req), 32'd0);

    // Retry loop: repeated update pulses while FILL is stalled
    cpu_addr = 32'h2080;
    #1;
    check("retry_cold", 32'(miss), 32'd1);
    pulse_update();
    for (int i = 0; i < 6; i++) begin
      update = (i % 2 == 1);
      tick();
      update = 1'b0;
      check("retry_req",  32'(mem_bus.mem_req), 32'd1);
      check("retry_addr", mem_bus.mem_addr, 32'h2080);
      check("retry_miss", 32'(miss), 32'd1);
    end
    fill_words(32'h2080, 32'hC0);
    check("retry_hit",   32'(miss), 32'd0);
    check("retry_rdata", cpu_rdata, 32'hC0);
    cpu_addr = 32'h208C;
    #1;
    check("retry_rdata3", cpu_rdata, 32'hC3);

    // Reset mid-FILL after two acks
    cpu_addr = 32'h3000;
    #1;
    pulse_update();
    for (int i = 0; i < 2; i++) begin
      mem_bus.mem_rdata = 32'hE0 + 32'(i);
      mem_bus.mem_ack = 1'b1;
      tick();
      mem_bus.mem_ack = 1'b0;
    end
    check("abort_addr", mem_bus.mem_addr, 32'h3008);
    #2;
    rst = 1'b1;
    #1;
    check("abort_req", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_miss", 32'(miss), 32'd1);
    cpu_addr = 32'h1044;
    #1;
    check("abort_old_miss", 32'(miss), 32'd1);
    tick();
    check("abort_idle", 32'(mem_bus.mem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
